// File: rtl/sub_operand_sequencer.sv
// ---------------------------------------------------------------------------
// sub_operand_sequencer
//
// Feeds operand pairs from a 2-entry input FIFO to an external 8-bit
// subtractor, one operation at a time, and holds each result (or a timeout
// marker) until downstream accepts it.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake for {in_a, in_b}
//   in_a, in_b            minuend, subtrahend
//   start                 one-cycle start pulse to the subtractor
//   op_a, op_b            operands presented to the subtractor
//   sub_rdy, sub_result   subtractor ready/done level and its result
//   out_valid/out_ready   downstream handshake for out_result/out_err
//   out_result            captured result (8'h00 on timeout)
//   out_err               result slot is a timeout rather than a real result
//   done_count            number of accepted results, wrapping at 8 bits
//
// TIMEOUT is the number of GUARD+WAIT cycles allowed after the start pulse
// before the slot is closed as a timeout.
// ---------------------------------------------------------------------------
module sub_operand_sequencer #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       start,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    input  logic       sub_rdy,
    input  logic [7:0] sub_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_err,
    output logic [7:0] done_count
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StGuard = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;

    // The counter holds the number of GUARD/WAIT cycles already spent, so the
    // last allowed WAIT cycle is the one that sees TIMEOUT-1.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] ent0_q, ent0_d;
    logic [15:0] ent1_q, ent1_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [7:0]  res_q, res_d;
    logic        err_q, err_d;
    logic [7:0]  done_q, done_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [15:0] head;

    // Input FIFO. in_ready depends only on occupancy, so a pop in the same
    // cycle never lets a push through while full.
    always_comb begin
        fifo_full  = (count_q == 2'd2);
        fifo_empty = (count_q == 2'd0);
        push       = in_valid && !fifo_full;
        pop        = (state_q == StIdle) && !fifo_empty && sub_rdy;
        head       = rd_ptr_q ? ent1_q : ent0_q;

        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (push) begin
            if (wr_ptr_q) begin
                ent1_d = {in_a, in_b};
            end else begin
                ent0_d = {in_a, in_b};
            end
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = done_q;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StIssue;
                    op_a_d  = head[15:8];
                    op_b_d  = head[7:0];
                end
            end
            StIssue: begin
                tmo_d   = 8'd0;
                state_d = StGuard;
            end
            StGuard: begin
                // The subtractor's rdy may still be stale here; ignore it.
                tmo_d   = tmo_q + 8'd1;
                state_d = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 8'd1;
                if (sub_rdy) begin
                    res_d   = sub_result;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (tmo_q >= TmoLast) begin
                    res_d   = 8'h00;
                    err_d   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    done_d  = done_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ent0_q   <= 16'h0000;
            ent1_q   <= 16'h0000;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            tmo_q    <= 8'd0;
            op_a_q   <= 8'h00;
            op_b_q   <= 8'h00;
            res_q    <= 8'h00;
            err_q    <= 1'b0;
            done_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        in_ready   = !fifo_full;
        start      = (state_q == StIssue);
        out_valid  = (state_q == StHold);
        op_a       = op_a_q;
        op_b       = op_b_q;
        out_result = res_q;
        out_err    = err_q;
        done_count = done_q;
    end

endmodule

// File: tb/tb_sub_operand_sequencer.sv
module tb_sub_operand_sequencer;

    localparam int unsigned TMO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       sub_rdy;
    logic [7:0] sub_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_err;
    logic [7:0] done_count;

    always #5 clk = ~clk;

    sub_operand_sequencer #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub_rdy    (sub_rdy),
        .sub_result (sub_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .done_count (done_count)
    );

    // Subtractor model: after a start it drops rdy for mdl_delay cycles
    // (forever while mdl_hang is set), then presents a-b with rdy high.
    int         mdl_delay = 0;
    bit         mdl_hang  = 1'b0;
    logic       busy;
    int         mcnt;
    logic [7:0] mres;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            mcnt <= 0;
            mres <= 8'h00;
        end else if (start) begin
            busy <= (mdl_delay != 0) || mdl_hang;
            mcnt <= mdl_delay;
            mres <= op_a - op_b;
        end else if (busy && !mdl_hang) begin
            if (mcnt <= 1) busy <= 1'b0;
            else mcnt <= mcnt - 1;
        end
    end

    assign sub_rdy    = !busy;
    assign sub_result = mres;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] st_q[$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          hold_exit_cyc = 0;
    logic [7:0]  exp_done = 8'h00;
    int          n_assert = 0;
    int          n_fail = 0;

    // Record start pulses and result handshakes as seen at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst && start) begin
            st_q.push_back({op_a, op_b});
            start_cyc = cyc;
        end
        if (!rst && out_valid && out_ready) hold_exit_cyc = cyc;
    end

    // Presents one pair starting at the current negedge and returns at the
    // negedge after it was accepted.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic err);
        int w;
        exp_t e;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_assert++;
        if (!in_ready) begin
            $display("FAIL push_accept: in_ready=%b, required 1 within 200 cycles", in_ready);
            n_fail++;
        end else begin
            e.a = a;
            e.b = b;
            e.res = err ? 8'h00 : a - b;
            e.err = err;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int w);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Scoreboard pop: waits for a result, compares it, then accepts it.
    task automatic drain_one(input string name);
        int w;
        exp_t e;
        logic [15:0] op;
        wait_valid(w);
        n_assert++;
        if (!out_valid || exp_q.size() == 0) begin
            $display("FAIL %s_valid: out_valid=%b queued=%0d, required a result", name, out_valid,
                     exp_q.size());
            n_fail++;
            return;
        end
        e = exp_q.pop_front();
        n_assert++;
        if (out_result !== e.res || out_err !== e.err) begin
            $display("FAIL %s_result: got %h err=%b, required %h err=%b", name, out_result, out_err,
                     e.res, e.err);
            n_fail++;
        end
        n_assert++;
        if (op_a !== e.a || op_b !== e.b) begin
            $display("FAIL %s_ops_hold: got %h/%h, required %h/%h", name, op_a, op_b, e.a, e.b);
            n_fail++;
        end
        n_assert++;
        op = (st_q.size() != 0) ? st_q.pop_front() : 16'hxxxx;
        if (op !== {e.a, e.b}) begin
            $display("FAIL %s_start_ops: got %h, required %h", name, op, {e.a, e.b});
            n_fail++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_done = exp_done + 8'd1;
        n_assert++;
        if (done_count !== exp_done || out_valid !== 1'b0) begin
            $display("FAIL %s_accept: done_count=%0d out_valid=%b, required %0d and 0", name,
                     done_count, out_valid, exp_done);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1 || start !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            $display("FAIL reset_ctrl: in_ready=%b start=%b out_valid=%b out_err=%b, required 1000",
                     in_ready, start, out_valid, out_err);
            n_fail++;
        end
        n_assert++;
        if (out_result !== 8'h00 || op_a !== 8'h00 || op_b !== 8'h00 || done_count !== 8'h00) begin
            $display("FAIL reset_data: res=%h op_a=%h op_b=%h done=%h, required all 00",
                     out_result, op_a, op_b, done_count);
            n_fail++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        mdl_delay = 5;
        push_pair(8'h54, 8'h43, 1'b0);
        drain_one("single");
        n_assert++;
        if (st_q.size() != 0) begin
            $display("FAIL single_starts: %0d extra start pulses, required 0", st_q.size());
            n_fail++;
        end
    endtask

    task automatic test_min_latency();
        int w;
        mdl_delay = 0;
        push_pair(8'h10, 8'h20, 1'b0);
        wait_valid(w);
        n_assert++;
        if (w != 4) begin
            $display("FAIL min_latency: got %0d cycles, required 4", w);
            n_fail++;
        end
        drain_one("min_latency");
    endtask

    task automatic test_back_to_back();
        int w;
        int h1;
        exp_t e;
        logic [15:0] op;
        mdl_delay = 2;
        out_ready = 1'b1;
        push_pair(8'h54, 8'h43, 1'b0);
        push_pair(8'h43, 8'h54, 1'b0);
        h1 = 0;
        for (int i = 0; i < 2; i++) begin
            wait_valid(w);
            n_assert++;
            if (!out_valid || exp_q.size() == 0) begin
                $display("FAIL b2b_valid%0d: out_valid=%b, required 1", i, out_valid);
                n_fail++;
            end else begin
                e = exp_q.pop_front();
                op = (st_q.size() != 0) ? st_q.pop_front() : 16'hxxxx;
                n_assert++;
                if (out_result !== e.res || out_err !== 1'b0 || op !== {e.a, e.b}) begin
                    $display("FAIL b2b_result%0d: got %h err=%b ops=%h, required %h err=0 ops=%h",
                             i, out_result, out_err, op, e.res, {e.a, e.b});
                    n_fail++;
                end
                if (i == 1) begin
                    n_assert++;
                    if (start_cyc - h1 != 2) begin
                        $display("FAIL b2b_gap: start %0d cycles after hold exit, required 2",
                                 start_cyc - h1);
                        n_fail++;
                    end
                end
            end
            @(negedge clk);
            exp_done = exp_done + 8'd1;
            h1 = hold_exit_cyc;
        end
        out_ready = 1'b0;
        n_assert++;
        if (done_count !== exp_done) begin
            $display("FAIL b2b_done: got %0d, required %0d", done_count, exp_done);
            n_fail++;
        end
    endtask

    task automatic test_full_fifo();
        int w;
        mdl_delay = 8;
        push_pair(8'h01, 8'h02, 1'b0);
        w = 0;
        while (st_q.size() == 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        push_pair(8'h03, 8'h04, 1'b0);
        push_pair(8'h05, 8'h06, 1'b0);
        in_valid = 1'b1;
        in_a = 8'h07;
        in_b = 8'h08;
        n_assert++;
        if (in_ready !== 1'b0) begin
            $display("FAIL full_refuse: in_ready=%b, required 0", in_ready);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b0) begin
            $display("FAIL full_refuse_hold: in_ready=%b, required 0", in_ready);
            n_fail++;
        end
        in_valid = 1'b0;
        drain_one("full_first");
        push_pair(8'h07, 8'h08, 1'b0);
        drain_one("full_second");
        drain_one("full_third");
        drain_one("full_fourth");
    endtask

    task automatic test_timeout();
        int w;
        mdl_delay = 1;
        mdl_hang = 1'b1;
        push_pair(8'h12, 8'h34, 1'b1);
        wait_valid(w);
        n_assert++;
        if (!out_valid || cyc - start_cyc != int'(TMO)) begin
            $display("FAIL timeout_cycle: out_valid=%b after %0d cycles, required 1 after %0d",
                     out_valid, cyc - start_cyc, TMO);
            n_fail++;
        end
        mdl_hang = 1'b0;
        drain_one("timeout");
        push_pair(8'h05, 8'h09, 1'b0);
        drain_one("after_timeout");
    endtask

    task automatic test_backpressure();
        int w;
        logic [7:0] r;
        exp_t e;
        mdl_delay = 1;
        push_pair(8'h80, 8'h01, 1'b0);
        wait_valid(w);
        r = out_result;
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (out_valid !== 1'b1 || out_result !== r || st_q.size() != 1) begin
                $display("FAIL backpressure_%0d: valid=%b res=%h starts=%0d, required 1 %h 1", i,
                         out_valid, out_result, st_q.size(), r);
                n_fail++;
            end
            if ((i == 2 || i == 3) && in_ready) begin
                in_valid = 1'b1;
                in_a = 8'(i);
                in_b = 8'h00;
                e.a = in_a;
                e.b = 8'h00;
                e.res = in_a;
                e.err = 1'b0;
                exp_q.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_assert++;
        if (in_ready !== 1'b0 || exp_q.size() != 3) begin
            $display("FAIL backpressure_fill: in_ready=%b queued=%0d, required 0 and 3", in_ready,
                     exp_q.size());
            n_fail++;
        end
        drain_one("bp_first");
        drain_one("bp_second");
        drain_one("bp_third");
    endtask

    task automatic test_reset_mid_wait();
        int w;
        mdl_delay = 20;
        push_pair(8'h44, 8'h22, 1'b0);
        w = 0;
        while (st_q.size() == 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_a = 8'h66;
        in_b = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || start !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midreset_ctrl: valid=%b start=%b err=%b in_ready=%b, required 0001",
                     out_valid, start, out_err, in_ready);
            n_fail++;
        end
        n_assert++;
        if (out_result !== 8'h00 || op_a !== 8'h00 || op_b !== 8'h00 || done_count !== 8'h00) begin
            $display("FAIL midreset_data: res=%h op_a=%h op_b=%h done=%h, required all 00",
                     out_result, op_a, op_b, done_count);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        st_q.delete();
        exp_done = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_assert++;
            if (out_valid !== 1'b0 || st_q.size() != 0) begin
                $display("FAIL midreset_quiet_%0d: valid=%b starts=%0d, required 0 and 0", i,
                         out_valid, st_q.size());
                n_fail++;
            end
        end
        mdl_delay = 3;
        push_pair(8'h66, 8'h11, 1'b0);
        drain_one("after_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_min_latency();
        test_back_to_back();
        test_full_fifo();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_operand_sequencer.md
SUB_OPERAND_SEQUENCER -- requirements
Module: sub_operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 32, max cycles waited for subtractor rdy after start (range 4..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  sequencer can accept a pair.
REQ-006 in_a, in_b  input  8 each  minuend, subtrahend.
REQ-007 start  output  1  start pulse to the 8-bit subtractor.
REQ-008 op_a, op_b  output  8 each  operands driven to the subtractor's A, B.
REQ-009 sub_rdy  input  1  subtractor ready/done level.
REQ-010 sub_result  input  8  subtractor result.
REQ-011 out_valid  output  1  result available downstream.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  8  captured result.
REQ-014 out_err  output  1  result slot is a timeout, not a real result.
REQ-015 done_count  output  8  count of completed (accepted) results.

Function
REQ-016 Input queue: 2-entry FIFO of {in_a,in_b}; push when in_valid && in_ready; in_ready = !full; no bypass when full, even if a pop occurs the same cycle.
REQ-017 FSM states: IDLE, ISSUE, GUARD, WAIT, HOLD.
REQ-018 IDLE -> ISSUE when FIFO non-empty and sub_rdy=1; head popped into op_a/op_b on that edge; otherwise stay IDLE.
REQ-019 ISSUE: start=1 for exactly one cycle; always -> GUARD.
REQ-020 GUARD: one cycle, sub_rdy ignored (covers subtractor's stale rdy); -> WAIT.
REQ-021 WAIT: first cycle with sub_rdy=1 captures sub_result into out_result, out_err=0, -> HOLD.
REQ-022 Timeout counter cleared in ISSUE, increments each GUARD/WAIT cycle; if it reaches TIMEOUT in WAIT without sub_rdy: out_result=8'h00, out_err=1, -> HOLD; sub_rdy and timeout same cycle: sub_rdy wins.
REQ-023 op_a/op_b change only on the IDLE->ISSUE edge and stay stable ISSUE through HOLD.
REQ-024 HOLD: out_valid=1, out_result/out_err stable; on out_ready=1 -> IDLE, done_count += 1 (wraps 8'hFF -> 8'h00, counts errors too).
REQ-025 out_valid=1 only in HOLD; start=1 only in ISSUE.
REQ-026 Minimum latency push -> out_valid: 4 cycles (IDLE pop, ISSUE, GUARD, WAIT capture); back-to-back: next ISSUE no earlier than 1 cycle after HOLD exit.
REQ-027 FIFO pushes continue in any state while not full; ordering strictly FIFO.

Reset
REQ-028 rst asserted at any time, including mid-operation: state=IDLE, FIFO emptied, start=0, out_valid=0, out_err=0, out_result=8'h00, op_a=op_b=8'h00, done_count=8'h00, timeout counter=0, in_ready=1 (after first edge, in_ready=1 while rst held).
REQ-029 In-flight subtraction aborted by reset is discarded; no result emitted.

Verification
REQ-030 Single op: push A=8'h54,B=8'h43, model returns 8'h11 after 5 cycles -> one start pulse, op_a/op_b=54/43 stable, out_valid with out_result=8'h11, out_err=0, done_count=1.
REQ-031 Back-to-back: push (54,43) then (43,54) in consecutive cycles, out_ready=1 -> two start pulses in order, results in order, in_ready never drops below capacity rules, done_count=2.
REQ-032 Full FIFO: three pushes while subtractor busy -> third refused (in_ready=0) until first pop; no pair lost or duplicated.
REQ-033 Timeout: model never raises sub_rdy after start, TIMEOUT=32 -> HOLD with out_result=8'h00, out_err=1 at timeout cycle; next pair proceeds normally.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_result stable, no new start, FIFO still accepts up to 2.
REQ-035 Reset mid-WAIT: assert rst in WAIT -> all REQ-028 values immediately, no out_valid after release until a new pair is pushed.
